// File: rtl/object_bbox_centroid_pkg.sv
// Shared frame geometry, datapath widths and controller state encoding
// for the object bounding-box / centroid block.
package object_bbox_centroid_pkg;

    localparam int FRAME_W_DEF = 160;
    localparam int FRAME_H_DEF = 120;
    localparam int MIN_AREA    = 64;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 15;
    localparam int SW = 22;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_DIV_X   = 3'd2,
        ST_DIV_Y   = 3'd3,
        ST_PUBLISH = 3'd4
    } state_t;

endpackage

// File: rtl/object_bbox_centroid_seq_divider.sv
// Unsigned 22-by-15 restoring divider, one quotient bit per cycle; load on i_start.
// Latency: o_done pulses in the 23rd cycle counting the start cycle; quotient final on the edge ending it.
module object_bbox_centroid_seq_divider
    import object_bbox_centroid_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [SW-1:0] i_dividend,
    input  logic [CW-1:0] i_divisor,
    output logic          o_done,
    output logic [XW-1:0] o_quotient
);

    logic          r_busy;
    logic [4:0]    r_iter;
    logic [SW-1:0] r_quo;
    logic [CW-1:0] r_rem;
    logic [CW-1:0] r_den;

    logic [CW:0]   w_trial;
    logic          w_ge;
    logic [CW-1:0] w_sub;

    // The remainder stays below the divisor, so the difference always fits CW bits.
    always_comb begin
        w_trial = {r_rem, r_quo[SW-1]};
        w_ge    = (w_trial >= {1'b0, r_den});
        w_sub   = w_trial[CW-1:0] - r_den;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_busy <= 1'b0;
            r_iter <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_iter <= 5'(SW);
            r_quo  <= i_dividend;
            r_rem  <= '0;
            r_den  <= i_divisor;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_sub : w_trial[CW-1:0];
            r_quo  <= {r_quo[SW-2:0], w_ge};
            r_iter <= r_iter - 5'd1;
            if (r_iter == 5'd1) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done     = r_busy && (r_iter == 5'd1);
    // A mean coordinate never exceeds the column range, so only the low byte is exported.
    assign o_quotient = r_quo[XW-1:0];

endmodule

// File: rtl/object_bbox_centroid.sv
// Per-frame bounding box, pixel count and integer centroid of a raster-order object mask.
// Optional OBJ_MIN_AREA_EN: objects smaller than MIN_AREA pixels are published as no_object.
module object_bbox_centroid
    import object_bbox_centroid_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pixel_valid,
    input  logic       i_frame_start,
    input  logic       i_object_image,
    output logic [7:0] o_min_x,
    output logic [7:0] o_max_x,
    output logic [6:0] o_min_y,
    output logic [6:0] o_max_y,
    output logic [14:0] o_pixel_count,
    output logic [7:0] o_centroid_x,
    output logic [6:0] o_centroid_y,
    output logic       o_no_object,
    output logic       o_result_valid,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_first;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_sum_x;
    logic [SW-1:0] r_sum_y;
    logic [XW-1:0] r_min_x, r_max_x;
    logic [YW-1:0] r_min_y, r_max_y;
    logic [XW-1:0] r_cx;
    logic          r_overrun;

    logic [XW-1:0] r_o_min_x, r_o_max_x, r_o_cx;
    logic [YW-1:0] r_o_min_y, r_o_max_y, r_o_cy;
    logic [CW-1:0] r_o_cnt;
    logic          r_o_no_obj;
    logic          r_o_vld;

    logic          w_accept;
    logic          w_restart;
    logic [XW-1:0] w_px;
    logic [YW-1:0] w_py;
    logic          w_last;
    logic [CW-1:0] w_cnt_base;
    logic [SW-1:0] w_sx_base, w_sy_base;
    logic          w_first_obj;
    logic          w_skip;
    logic          w_busy;
    logic          w_div_start;
    logic [SW-1:0] w_div_dividend;
    logic          w_div_done;
    logic [XW-1:0] w_quo;

    // A frame_start pixel restarts the frame at (0,0) with empty accumulators.
    always_comb begin
        w_accept    = i_pixel_valid &&
                      (((r_state == ST_IDLE) && i_frame_start) || (r_state == ST_ACCUM));
        w_restart   = i_frame_start;
        w_px        = w_restart ? '0 : r_x;
        w_py        = w_restart ? '0 : r_y;
        w_last      = (w_px == X_LAST) && (w_py == Y_LAST);
        w_cnt_base  = w_restart ? '0 : r_cnt;
        w_sx_base   = w_restart ? '0 : r_sum_x;
        w_sy_base   = w_restart ? '0 : r_sum_y;
        w_first_obj = (w_cnt_base == '0);
`ifdef OBJ_MIN_AREA_EN
        w_skip      = (r_cnt < CW'(MIN_AREA));
`else
        w_skip      = (r_cnt == '0);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_first <= (w_state_next != r_state);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_state_next = w_last ? ST_DIV_X : ST_ACCUM;
            ST_ACCUM:   if (w_accept && w_last) w_state_next = ST_DIV_X;
            ST_DIV_X: begin
                if (r_first && w_skip)  w_state_next = ST_PUBLISH;
                else if (w_div_done)    w_state_next = ST_DIV_Y;
            end
            ST_DIV_Y:   if (w_div_done) w_state_next = ST_PUBLISH;
            ST_PUBLISH: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy         = (r_state == ST_DIV_X) || (r_state == ST_DIV_Y) ||
                         (r_state == ST_PUBLISH);
        w_div_start    = r_first && (((r_state == ST_DIV_X) && !w_skip) ||
                                     (r_state == ST_DIV_Y));
        w_div_dividend = (r_state == ST_DIV_Y) ? r_sum_y : r_sum_x;
    end

    object_bbox_centroid_seq_divider u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_div_start),
        .i_dividend (w_div_dividend),
        .i_divisor  (r_cnt),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_min_x <= '0;
            r_max_x <= '0;
            r_min_y <= '0;
            r_max_y <= '0;
        end else if (w_accept) begin
            r_x     <= (w_px == X_LAST) ? '0 : w_px + 8'd1;
            r_y     <= (w_px == X_LAST) ? w_py + 7'd1 : w_py;
            r_cnt   <= w_cnt_base;
            r_sum_x <= w_sx_base;
            r_sum_y <= w_sy_base;
            if (i_object_image) begin
                r_cnt   <= w_cnt_base + 15'd1;
                r_sum_x <= w_sx_base + {14'd0, w_px};
                r_sum_y <= w_sy_base + {15'd0, w_py};
                r_min_x <= (w_first_obj || (w_px < r_min_x)) ? w_px : r_min_x;
                r_max_x <= (w_first_obj || (w_px > r_max_x)) ? w_px : r_max_x;
                r_min_y <= (w_first_obj || (w_py < r_min_y)) ? w_py : r_min_y;
                r_max_y <= (w_first_obj || (w_py > r_max_y)) ? w_py : r_max_y;
            end
        end
    end

    // The X quotient is parked while the divider is reused for Y.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cx       <= '0;
            r_overrun  <= 1'b0;
            r_o_min_x  <= '0;
            r_o_max_x  <= '0;
            r_o_min_y  <= '0;
            r_o_max_y  <= '0;
            r_o_cnt    <= '0;
            r_o_cx     <= '0;
            r_o_cy     <= '0;
            r_o_no_obj <= 1'b0;
            r_o_vld    <= 1'b0;
        end else begin
            r_o_vld <= 1'b0;
            if (i_pixel_valid && w_busy) begin
                r_overrun <= 1'b1;
            end
            if ((r_state == ST_DIV_Y) && r_first) begin
                r_cx <= w_quo;
            end
            if (r_state == ST_PUBLISH) begin
                r_o_vld    <= 1'b1;
                r_o_cnt    <= r_cnt;
                r_o_no_obj <= w_skip;
                r_o_min_x  <= w_skip ? '0 : r_min_x;
                r_o_max_x  <= w_skip ? '0 : r_max_x;
                r_o_min_y  <= w_skip ? '0 : r_min_y;
                r_o_max_y  <= w_skip ? '0 : r_max_y;
                r_o_cx     <= w_skip ? '0 : r_cx;
                r_o_cy     <= w_skip ? '0 : w_quo[YW-1:0];
            end
        end
    end

    assign o_min_x        = r_o_min_x;
    assign o_max_x        = r_o_max_x;
    assign o_min_y        = r_o_min_y;
    assign o_max_y        = r_o_max_y;
    assign o_pixel_count  = r_o_cnt;
    assign o_centroid_x   = r_o_cx;
    assign o_centroid_y   = r_o_cy;
    assign o_no_object    = r_o_no_obj;
    assign o_result_valid = r_o_vld;
    assign o_busy         = w_busy;
    assign o_overrun      = r_overrun;

endmodule

// File: doc/object_bbox_centroid.md
Name: object_bbox_centroid

Overview:
- Downstream consumer of the skin/background segmentation stage.
- Takes the 1-bit per-pixel object mask in raster order, one frame of FRAME_W x FRAME_H pixels.
- Accumulates the object's bounding box, pixel count and coordinate sums, then computes the integer centroid with a shared sequential divider.
- Publishes one result set per frame to the gesture classifier.

Parameters:
- FRAME_W, 160, pixels per line.
- FRAME_H, 120, lines per frame.
- MIN_AREA, 64, minimum object pixel count; used only when OBJ_MIN_AREA_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pixel_valid  in  1  object_image is valid this cycle.
- frame_start  in  1  qualifies the first pixel of a frame; meaningful only with pixel_valid.
- object_image  in  1  1 = object pixel.
- min_x, max_x  out  8  bounding-box columns.
- min_y, max_y  out  7  bounding-box rows.
- pixel_count  out  15  object pixels in the frame (max 19200).
- centroid_x  out  8  floor(sum_x / pixel_count).
- centroid_y  out  7  floor(sum_y / pixel_count).
- no_object  out  1  frame contained no qualifying object.
- result_valid  out  1  one-cycle pulse; all result outputs are updated in the same cycle.
- busy  out  1  high in DIV_X, DIV_Y and PUBLISH.
- overrun  out  1  sticky; set when a pixel arrives while busy.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, state is IDLE, all accumulators and counters are 0.
- Accumulator widths:
  - sum_x and sum_y are 22 bits (159*19200 < 2^22).
  - Column counter x is 8 bits; row counter y is 7 bits.
- IDLE:
  - Waits for pixel_valid && frame_start.
  - That pixel is processed as (0,0) and the state moves to ACCUM.
  - Non-start pixels in IDLE are dropped silently.
- ACCUM, per valid pixel:
  - If object_image=1: pixel_count+=1, sum_x+=x, sum_y+=y, and min/max are updated. The first object pixel loads min and max directly.
  - x wraps from FRAME_W-1 to 0 and increments y.
  - On the pixel at (FRAME_W-1, FRAME_H-1), go to DIV_X.
  - pixel_valid low: stall, no state change.
- frame_start with pixel_valid during ACCUM: discard the partial frame, clear the accumulators, and treat that pixel as (0,0) of a new frame.
- DIV_X: the sub-divider computes sum_x / pixel_count.
  - 1 load cycle plus 22 iteration cycles (restoring division, one quotient bit per cycle).
  - Then DIV_Y performs the same operation on sum_y.
- Zero count: if pixel_count==0, both divisions are skipped (go directly to PUBLISH) with centroid=0, bbox=0, no_object=1.
- PUBLISH: registers the outputs, pulses result_valid for exactly one cycle, then returns to IDLE.
- Latency: result_valid is high on the 47th rising edge after the edge that accepted the last pixel (non-empty frame). For an empty frame it is the 2nd edge.
- Busy period:
  - pixel_valid during DIV_X, DIV_Y or PUBLISH: the pixel is dropped and overrun is set.
  - overrun is cleared only by reset.
  - frame_start during busy is likewise ignored.
- Between result_valid pulses, the result outputs hold their last published values.
- Reset mid-division: aborts immediately, no result_valid, outputs return to 0.

Optional Feature:
- Macro: OBJ_MIN_AREA_EN.
- Defined: if pixel_count < MIN_AREA at frame end, the divisions are skipped and the result is published as no_object=1 with centroid and bbox forced to 0. pixel_count still reports the true count.
- Undefined: MIN_AREA is unused; any count >= 1 is an object.

Decomposition:
- Shared package:
  - FRAME_W and FRAME_H defaults.
  - Coordinate widths (8/7).
  - Count width (15) and sum width (22).
  - State encoding for IDLE/ACCUM/DIV_X/DIV_Y/PUBLISH.
- Sub-module seq_divider:
  - Unsigned 22-bit by 15-bit restoring divider.
  - start/done handshake, fixed 23-cycle latency.
  - Instantiated once and reused for X then Y.

Test Plan:
- Single object pixel at (10,5), rest 0 -> bbox 10..10 / 5..5, count 1, centroid (10,5), no_object 0, result_valid exactly 47 edges after the last pixel.
- Solid rectangle x 20..29, y 40..49 -> count 100, sum_x 2450 gives centroid_x 24 (truncation check), centroid_y 44, bbox 20..29 / 40..49.
- All-zero frame -> no_object 1, count 0, centroid 0, result_valid 2 edges after the last pixel.
- frame_start reasserted at pixel 5000 of a frame containing object pixels -> the earlier pixels do not affect the result; the new frame's rectangle is reported alone.
- Full frame of ones (19200) -> count 19200, centroid (79,59), bbox 0..159 / 0..119, no accumulator overflow. pixel_valid pulsed during DIV_Y -> overrun 1, result unchanged.
- rst asserted mid-DIV_X -> all outputs 0 asynchronously, no result_valid. With OBJ_MIN_AREA_EN and a 50-pixel blob -> no_object 1, count 50.
